// File: rtl/cache_bus_pkg.sv
// Shared definitions for the two-client cache bus arbiter: state encoding and
// default address/line widths.
package cache_bus_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LINE_W = 128;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    READ     = 2'd2,
    WAIT_RET = 2'd3
  } bus_state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: the pointed-to client wins when it requests,
// otherwise the other one does. Grant is one-hot or zero.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = 2'b00;
    if (req[ptr])       gnt[ptr]  = 1'b1;
    else if (req[~ptr]) gnt[~ptr] = 1'b1;
  end
endmodule

// File: rtl/cache_bus_arbiter.sv
// Arbitrates two cache clients onto a single memory port. A granted client's
// write-back is issued before its refill; the refill line is returned one cycle
// after memory presents it.
module cache_bus_arbiter
  import cache_bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c0_rd_req,
  input  logic [ADDR_W-1:0] c0_rd_addr,
  output logic              c0_rd_rdy,
  input  logic              c0_wr_req,
  input  logic [ADDR_W-1:0] c0_wr_addr,
  input  logic [LINE_W-1:0] c0_wr_data,
  output logic              c0_wr_rdy,
  output logic              c0_ret_valid,
  output logic [LINE_W-1:0] c0_ret_data,
  input  logic              c1_rd_req,
  input  logic [ADDR_W-1:0] c1_rd_addr,
  output logic              c1_rd_rdy,
  input  logic              c1_wr_req,
  input  logic [ADDR_W-1:0] c1_wr_addr,
  input  logic [LINE_W-1:0] c1_wr_data,
  output logic              c1_wr_rdy,
  output logic              c1_ret_valid,
  output logic [LINE_W-1:0] c1_ret_data,
  output logic              m_rd_req,
  output logic [ADDR_W-1:0] m_rd_addr,
  input  logic              m_rd_rdy,
  output logic              m_wr_req,
  output logic [ADDR_W-1:0] m_wr_addr,
  output logic [LINE_W-1:0] m_wr_data,
  input  logic              m_wr_rdy,
  input  logic              m_ret_valid,
  input  logic [LINE_W-1:0] m_ret_data
);
  bus_state_t              state, state_nx;
  logic                    ptr, owner, rd_pend, done, gidx;
  logic [1:0]              req, gnt, ret_valid;
  logic [1:0][LINE_W-1:0]  ret_data;

  assign req  = {c1_rd_req | c1_wr_req, c0_rd_req | c0_wr_req};
  assign gidx = gnt[1];

  rr_arbiter2 u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (gnt)
  );

  // done marks the last handshake of a grant; the pointer moves on there.
  always_comb begin
    state_nx = state;
    done     = 1'b0;
    case (state)
      IDLE:
        if (|gnt) state_nx = (gidx ? c1_wr_req : c0_wr_req) ? WRITE : READ;
      WRITE:
        if (m_wr_rdy) begin
          state_nx = rd_pend ? READ : IDLE;
          done     = !rd_pend;
        end
      READ:
        if (m_rd_rdy) state_nx = WAIT_RET;
      WAIT_RET:
        if (m_ret_valid) begin
          state_nx = IDLE;
          done     = 1'b1;
        end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      owner     <= 1'b0;
      rd_pend   <= 1'b0;
      m_rd_addr <= '0;
      m_wr_addr <= '0;
      m_wr_data <= '0;
      ret_valid <= '0;
      ret_data  <= '0;
    end else begin
      state     <= state_nx;
      ret_valid <= '0;
      if (done) ptr <= ~owner;
      // Everything the memory side sees is captured here, so clients may
      // change their inputs freely once granted.
      if (state == IDLE && |gnt) begin
        owner     <= gidx;
        rd_pend   <= gidx ? c1_rd_req  : c0_rd_req;
        m_rd_addr <= gidx ? c1_rd_addr : c0_rd_addr;
        m_wr_addr <= gidx ? c1_wr_addr : c0_wr_addr;
        m_wr_data <= gidx ? c1_wr_data : c0_wr_data;
      end
      if (state == WAIT_RET && m_ret_valid) begin
        ret_valid[owner] <= 1'b1;
        ret_data[owner]  <= m_ret_data;
      end
    end
  end

  assign m_wr_req     = (state == WRITE);
  assign m_rd_req     = (state == READ);
  assign c0_wr_rdy    = m_wr_req && m_wr_rdy && !owner;
  assign c1_wr_rdy    = m_wr_req && m_wr_rdy &&  owner;
  assign c0_rd_rdy    = m_rd_req && m_rd_rdy && !owner;
  assign c1_rd_rdy    = m_rd_req && m_rd_rdy &&  owner;
  assign c0_ret_valid = ret_valid[0];
  assign c1_ret_valid = ret_valid[1];
  assign c0_ret_data  = ret_data[0];
  assign c1_ret_data  = ret_data[1];
endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter: a transaction-order model predicts the
// memory ops and client pulses, checked every cycle, plus literal pins per scenario.
module tb_cache_bus_arbiter;
  localparam int AW = 32;
  localparam int LW = 128;

  logic clk = 1'b0;
  logic rst;
  logic c0_rd_req, c1_rd_req, c0_wr_req, c1_wr_req;
  logic [AW-1:0] c0_rd_addr, c1_rd_addr, c0_wr_addr, c1_wr_addr;
  logic [LW-1:0] c0_wr_data, c1_wr_data;
  logic c0_rd_rdy, c1_rd_rdy, c0_wr_rdy, c1_wr_rdy, c0_ret_valid, c1_ret_valid;
  logic [LW-1:0] c0_ret_data, c1_ret_data;
  logic m_rd_req, m_wr_req, m_rd_rdy, m_wr_rdy, m_ret_valid;
  logic [AW-1:0] m_rd_addr, m_wr_addr;
  logic [LW-1:0] m_wr_data, m_ret_data;

  always #5 clk = ~clk;

  cache_bus_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .c0_rd_req(c0_rd_req), .c0_rd_addr(c0_rd_addr), .c0_rd_rdy(c0_rd_rdy),
    .c0_wr_req(c0_wr_req), .c0_wr_addr(c0_wr_addr), .c0_wr_data(c0_wr_data),
    .c0_wr_rdy(c0_wr_rdy), .c0_ret_valid(c0_ret_valid), .c0_ret_data(c0_ret_data),
    .c1_rd_req(c1_rd_req), .c1_rd_addr(c1_rd_addr), .c1_rd_rdy(c1_rd_rdy),
    .c1_wr_req(c1_wr_req), .c1_wr_addr(c1_wr_addr), .c1_wr_data(c1_wr_data),
    .c1_wr_rdy(c1_wr_rdy), .c1_ret_valid(c1_ret_valid), .c1_ret_data(c1_ret_data),
    .m_rd_req(m_rd_req), .m_rd_addr(m_rd_addr), .m_rd_rdy(m_rd_rdy),
    .m_wr_req(m_wr_req), .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data),
    .m_wr_rdy(m_wr_rdy), .m_ret_valid(m_ret_valid), .m_ret_data(m_ret_data)
  );

  typedef struct {
    bit            wr;
    bit            cl;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } op_t;

  // model state
  op_t           exp_q[$];
  bit            ptr_m, out_valid, out_cl;
  logic [1:0]    exp_retv;
  logic [LW-1:0] exp_rdata [2];
  // observation stats
  int checks = 0, errors = 0, cyc = 0;
  int rd_pulses [2], wr_pulses [2], ret_pulses [2], wr_rdy_cyc [2], rd_rdy_cyc [2];
  int rd_order[$];
  logic [AW-1:0] seen_wr_addr, seen_rd_addr;
  logic [LW-1:0] seen_wr_data;
  // memory responder
  int wr_lat, rd_lat, ret_lat, wcnt, qcnt, rcnt;
  bit rpend, fixed_ret;
  logic [AW-1:0] raddr;
  logic [LW-1:0] fixed_val;

  task automatic cmp(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmpi(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 2; i++) begin
      rd_pulses[i] = 0; wr_pulses[i] = 0; ret_pulses[i] = 0;
      wr_rdy_cyc[i] = 0; rd_rdy_cyc[i] = 0;
    end
    rd_order.delete();
  endtask

  // Expected memory order for the requests currently presented: clients in
  // round-robin order, write-back before refill, pointer to the other client.
  task automatic plan();
    op_t o;
    bit  first, c, w, r;
    first = ptr_m;
    for (int k = 0; k < 2; k++) begin
      c = first ^ k[0];
      w = c ? c1_wr_req : c0_wr_req;
      r = c ? c1_rd_req : c0_rd_req;
      if (w) begin
        o.wr = 1'b1; o.cl = c;
        o.addr = c ? c1_wr_addr : c0_wr_addr;
        o.data = c ? c1_wr_data : c0_wr_data;
        exp_q.push_back(o);
      end
      if (r) begin
        o.wr = 1'b0; o.cl = c;
        o.addr = c ? c1_rd_addr : c0_rd_addr;
        o.data = '0;
        exp_q.push_back(o);
      end
      if (w || r) ptr_m = ~c;
    end
  endtask

  task automatic check();
    logic [1:0] ewr, erd;
    cyc++;
    if (rst) begin
      cmp("rst_ctl", LW'({m_rd_req, m_wr_req, c0_rd_rdy, c1_rd_rdy, c0_wr_rdy,
                          c1_wr_rdy, c0_ret_valid, c1_ret_valid}), '0);
      cmp("rst_addr", LW'({m_rd_addr, m_wr_addr}), '0);
      cmp("rst_wdata", m_wr_data, '0);
      cmp("rst_ret0", c0_ret_data, '0);
      cmp("rst_ret1", c1_ret_data, '0);
      exp_q.delete();
      out_valid = 1'b0; ptr_m = 1'b0; exp_retv = '0;
      exp_rdata[0] = '0; exp_rdata[1] = '0;
      return;
    end
    ewr = '0; erd = '0;
    cmp("req_excl", LW'(m_rd_req & m_wr_req), '0);
    if (m_wr_req) begin
      if (exp_q.size() == 0 || !exp_q[0].wr) cmp("m_wr_req_unexp", LW'(m_wr_req), '0);
      else begin
        cmp("m_wr_addr", LW'(m_wr_addr), LW'(exp_q[0].addr));
        cmp("m_wr_data", m_wr_data, exp_q[0].data);
        if (m_wr_rdy) begin
          ewr[exp_q[0].cl] = 1'b1;
          seen_wr_addr = m_wr_addr; seen_wr_data = m_wr_data;
          void'(exp_q.pop_front());
        end
      end
    end
    if (m_rd_req) begin
      if (exp_q.size() == 0 || exp_q[0].wr) cmp("m_rd_req_unexp", LW'(m_rd_req), '0);
      else begin
        cmp("m_rd_addr", LW'(m_rd_addr), LW'(exp_q[0].addr));
        if (m_rd_rdy) begin
          erd[exp_q[0].cl] = 1'b1;
          out_valid = 1'b1; out_cl = exp_q[0].cl;
          seen_rd_addr = m_rd_addr;
          void'(exp_q.pop_front());
        end
      end
    end
    cmp("wr_rdy", LW'({c1_wr_rdy, c0_wr_rdy}), LW'(ewr));
    cmp("rd_rdy", LW'({c1_rd_rdy, c0_rd_rdy}), LW'(erd));
    cmp("ret_valid", LW'({c1_ret_valid, c0_ret_valid}), LW'(exp_retv));
    cmp("ret_data0", c0_ret_data, exp_rdata[0]);
    cmp("ret_data1", c1_ret_data, exp_rdata[1]);
    if (c0_wr_rdy) begin wr_pulses[0]++; wr_rdy_cyc[0] = cyc; end
    if (c1_wr_rdy) begin wr_pulses[1]++; wr_rdy_cyc[1] = cyc; end
    if (c0_rd_rdy) begin rd_pulses[0]++; rd_rdy_cyc[0] = cyc; rd_order.push_back(0); end
    if (c1_rd_rdy) begin rd_pulses[1]++; rd_rdy_cyc[1] = cyc; rd_order.push_back(1); end
    if (c0_ret_valid) ret_pulses[0]++;
    if (c1_ret_valid) ret_pulses[1]++;
    exp_retv = '0;
    if (m_ret_valid && out_valid) begin
      exp_retv[out_cl]  = 1'b1;
      exp_rdata[out_cl] = m_ret_data;
      out_valid = 1'b0;
    end
  endtask

  // One clock: check at the falling edge, then after the rising edge let the
  // clients drop accepted requests and advance the memory responder.
  task automatic step();
    logic hr, w0, w1, r0, r1;
    @(negedge clk);
    check();
    hr = m_rd_req && m_rd_rdy && !rst;
    w0 = c0_wr_rdy; w1 = c1_wr_rdy; r0 = c0_rd_rdy; r1 = c1_rd_rdy;
    if (hr) raddr = m_rd_addr;
    @(posedge clk);
    #1;
    if (w0) c0_wr_req = 1'b0;
    if (w1) c1_wr_req = 1'b0;
    if (r0) c0_rd_req = 1'b0;
    if (r1) c1_rd_req = 1'b0;
    m_wr_rdy = 1'b0; m_rd_rdy = 1'b0; m_ret_valid = 1'b0;
    if (hr) begin rpend = 1'b1; rcnt = 0; end
    else if (rpend) begin
      if (rcnt >= ret_lat) begin
        m_ret_valid = 1'b1;
        m_ret_data  = fixed_ret ? fixed_val : {4{raddr}};
        rpend = 1'b0;
      end else rcnt++;
    end
    if (m_wr_req) begin
      if (wcnt >= wr_lat) begin m_wr_rdy = 1'b1; wcnt = 0; end else wcnt++;
    end else wcnt = 0;
    if (m_rd_req) begin
      if (qcnt >= rd_lat) begin m_rd_rdy = 1'b1; qcnt = 0; end else qcnt++;
    end else qcnt = 0;
  endtask

  task automatic drain(string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid || exp_retv != 2'b00 || rpend) && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s_timeout: got %0d cycles expected < 200", name, n);
    end
    step(); step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    int n;
    {c0_rd_req, c1_rd_req, c0_wr_req, c1_wr_req} = '0;
    {c0_rd_addr, c1_rd_addr, c0_wr_addr, c1_wr_addr} = '0;
    c0_wr_data = '0; c1_wr_data = '0;
    m_rd_rdy = 1'b0; m_wr_rdy = 1'b0; m_ret_valid = 1'b0; m_ret_data = '0;
    wr_lat = 1; rd_lat = 2; ret_lat = 1;
    wcnt = 0; qcnt = 0; rcnt = 0; rpend = 1'b0; raddr = '0;
    fixed_ret = 1'b0; fixed_val = '0;
    ptr_m = 1'b0; out_valid = 1'b0; out_cl = 1'b0; exp_retv = '0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    clear_stats();
    rst = 1'b1;
    step(); step(); step();
    rst = 1'b0;
    step();

    // single client-0 refill
    clear_stats();
    fixed_ret = 1'b1; fixed_val = {4{32'hAAAA_AAAA}};
    c0_rd_addr = 32'h0000_1000; c0_rd_req = 1'b1;
    plan();
    drain("t1");
    cmpi("t1_c0_rd_pulses", rd_pulses[0], 1);
    cmpi("t1_c0_ret_pulses", ret_pulses[0], 1);
    cmp("t1_c0_ret_data", c0_ret_data, {4{32'hAAAA_AAAA}});
    cmpi("t1_c1_silent", rd_pulses[1] + wr_pulses[1] + ret_pulses[1], 0);
    fixed_ret = 1'b0;

    // client-1 write-back then refill
    clear_stats();
    c1_wr_addr = 32'h2000; c1_wr_data = 128'h1234; c1_rd_addr = 32'h3000;
    c1_wr_req = 1'b1; c1_rd_req = 1'b1;
    plan();
    drain("t2");
    cmp("t2_wr_addr", LW'(seen_wr_addr), LW'(32'h2000));
    cmp("t2_wr_data", seen_wr_data, 128'h1234);
    cmp("t2_rd_addr", LW'(seen_rd_addr), LW'(32'h3000));
    cmpi("t2_wr_before_rd", int'(wr_rdy_cyc[1] < rd_rdy_cyc[1]), 1);
    cmpi("t2_c1_wr_pulses", wr_pulses[1], 1);
    cmp("t2_c1_ret_data", c1_ret_data, {4{32'h3000}});

    // simultaneous pairs from reset
    do_reset();
    clear_stats();
    c0_rd_addr = 32'h4000; c1_rd_addr = 32'h5000;
    c0_rd_req = 1'b1; c1_rd_req = 1'b1;
    plan();
    drain("t3a");
    c0_rd_addr = 32'h4100; c1_rd_addr = 32'h5100;
    c0_rd_req = 1'b1; c1_rd_req = 1'b1;
    plan();
    drain("t3b");
    cmpi("t3_grants", rd_order.size(), 4);
    if (rd_order.size() == 4) begin
      cmpi("t3_first", rd_order[0], 0);
      cmpi("t3_second", rd_order[1], 1);
      cmpi("t3_third", rd_order[2], 0);
      cmpi("t3_fourth", rd_order[3], 1);
    end

    // reset while waiting for the refill
    clear_stats();
    ret_lat = 6;
    c1_rd_addr = 32'h6000; c1_rd_req = 1'b1;
    plan();
    n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
    cmpi("t4_reached_wait", int'(out_valid), 1);
    step();
    do_reset();
    repeat (10) step();
    cmpi("t4_no_ret", ret_pulses[0] + ret_pulses[1], 0);
    ret_lat = 1;
    clear_stats();
    c0_rd_addr = 32'h7000; c1_rd_addr = 32'h7100;
    c0_rd_req = 1'b1; c1_rd_req = 1'b1;
    plan();
    drain("t4");
    cmpi("t4_ptr_c0", rd_order.size() > 0 ? rd_order[0] : -1, 0);

    // spurious return while idle
    clear_stats();
    m_ret_valid = 1'b1; m_ret_data = 128'hDEAD;
    step(); step(); step();
    cmpi("t5_no_ret", ret_pulses[0] + ret_pulses[1], 0);
    cmp("t5_c0_hold", c0_ret_data, {4{32'h7000}});
    cmp("t5_c1_hold", c1_ret_data, {4{32'h7100}});

    // both clients write-back only
    clear_stats();
    c0_wr_addr = 32'h8000; c0_wr_data = 128'h8888; c0_wr_req = 1'b1;
    c1_wr_addr = 32'h9000; c1_wr_data = 128'h9999; c1_wr_req = 1'b1;
    plan();
    drain("t6");
    cmpi("t6_wr_pulses", wr_pulses[0] + wr_pulses[1], 2);
    cmpi("t6_c0_first", int'(wr_rdy_cyc[0] < wr_rdy_cyc[1]), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
